// File: rtl/ray_gen_stream_if.sv
// Ray output stream: one primary-ray beat per pixel, valid/ready handshake.
// master drives valid and the payload; slave drives ready.
// Payload: signed ray direction, pixel column/row and linear pixel index.
interface ray_gen_stream_if #(
    parameter int COORD_W = 12,
    parameter int DIM_W   = 13,
    parameter int IDX_W   = 26
);
    logic                      ray_valid;
    logic                      ray_ready;
    logic signed [COORD_W-1:0] ray_dir_x;
    logic signed [COORD_W-1:0] ray_dir_y;
    logic signed [COORD_W-1:0] ray_dir_z;
    logic        [DIM_W-1:0]   ray_px;
    logic        [DIM_W-1:0]   ray_py;
    logic        [IDX_W-1:0]   ray_index;

    modport master (
        output ray_valid, ray_dir_x, ray_dir_y, ray_dir_z, ray_px, ray_py, ray_index,
        input  ray_ready
    );

    modport slave (
        input  ray_valid, ray_dir_x, ray_dir_y, ray_dir_z, ray_px, ray_py, ray_index,
        output ray_ready
    );
endinterface

// File: rtl/ray_gen_stream.sv
// Per-core primary-ray generator: walks pixels core_id, core_id+stride, ... emitting dir+right*u+up*v.
// Latency: start -> first ray_valid 4 cycles; accept -> next ray_valid 3 cycles.
// Backpressure: beat held stable while ray_ready low; valid never depends on ready combinationally.
// Ports: clk/reset_n (sync, active-low); start, core_id, num_cores_m1, image_width/height and
// cam_dir/right/up vectors are sampled on an accepted start; ray (master) carries the output
// stream; busy is high for the whole frame, done pulses for one cycle at frame end.
module ray_gen_stream #(
    parameter int COORD_W   = 12,
    parameter int DIM_W     = 13,
    parameter int IDX_W     = 26,
    parameter int CORE_W    = 3,
    parameter int SKIP_ZERO = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic        [CORE_W-1:0]  core_id,
    input  logic        [CORE_W-1:0]  num_cores_m1,
    input  logic        [DIM_W-1:0]   image_width,
    input  logic        [DIM_W-1:0]   image_height,
    input  logic signed [COORD_W-1:0] cam_dir_x,
    input  logic signed [COORD_W-1:0] cam_dir_y,
    input  logic signed [COORD_W-1:0] cam_dir_z,
    input  logic signed [COORD_W-1:0] cam_right_x,
    input  logic signed [COORD_W-1:0] cam_right_y,
    input  logic signed [COORD_W-1:0] cam_right_z,
    input  logic signed [COORD_W-1:0] cam_up_x,
    input  logic signed [COORD_W-1:0] cam_up_y,
    input  logic signed [COORD_W-1:0] cam_up_z,
    ray_gen_stream_if.master          ray,
    output logic                      busy,
    output logic                      done
);
    // u/v need one bit beyond DIM_W to hold signed centred offsets.
    localparam int UV_W   = DIM_W + 1;
    localparam int PROD_W = COORD_W + UV_W;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_COORD, S_MAC, S_EMIT, S_FINISH
    } state_t;

    state_t                    state;
    logic        [DIM_W-1:0]   w_r, h_r, stride_r;
    logic        [CORE_W-1:0]  core_r;
    logic signed [COORD_W-1:0] dir_x_r, dir_y_r, dir_z_r;
    logic signed [COORD_W-1:0] right_x_r, right_y_r, right_z_r;
    logic signed [COORD_W-1:0] up_x_r, up_y_r, up_z_r;
    logic        [IDX_W-1:0]   total_r, idx_r;
    logic        [DIM_W-1:0]   px_r, py_r;
    logic signed [UV_W-1:0]    u_r, v_r;
    logic                      skip_r;

    // Full-precision MAC; only the low COORD_W bits are kept, so the result wraps.
    function automatic logic [COORD_W-1:0] mac3(
        input logic signed [COORD_W-1:0] d,
        input logic signed [COORD_W-1:0] r,
        input logic signed [COORD_W-1:0] p,
        input logic signed [UV_W-1:0]    a,
        input logic signed [UV_W-1:0]    b
    );
        logic signed [PROD_W-1:0] acc;
        acc = PROD_W'(d) + PROD_W'(r) * PROD_W'(a) + PROD_W'(p) * PROD_W'(b);
        return COORD_W'(acc);
    endfunction

    logic [COORD_W-1:0] mac_x, mac_y, mac_z;
    assign mac_x = mac3(dir_x_r, right_x_r, up_x_r, u_r, v_r);
    assign mac_y = mac3(dir_y_r, right_y_r, up_y_r, u_r, v_r);
    assign mac_z = mac3(dir_z_r, right_z_r, up_z_r, u_r, v_r);

    logic mac_zero;
    assign mac_zero = (mac_x == '0) && (mac_y == '0) && (mac_z == '0);

    logic [CORE_W:0] stride_in;
    assign stride_in = {1'b0, num_cores_m1} + (CORE_W+1)'(1);

    logic [IDX_W-1:0] total_c;
    assign total_c = IDX_W'(w_r) * IDX_W'(h_r);

    // Incremental pixel walk: stride <= W guarantees at most one row wrap per step.
    logic [DIM_W:0]   px_sum;
    logic             px_wrap;
    logic [DIM_W-1:0] px_next, py_next;
    logic [IDX_W-1:0] idx_next;
    logic             frame_end;
    logic             accept;

    assign px_sum    = {1'b0, px_r} + {1'b0, stride_r};
    assign px_wrap   = px_sum >= {1'b0, w_r};
    assign px_next   = px_wrap ? DIM_W'(px_sum - {1'b0, w_r}) : DIM_W'(px_sum);
    assign py_next   = py_r + DIM_W'(px_wrap);
    assign idx_next  = idx_r + IDX_W'(stride_r);
    assign frame_end = idx_next >= total_r;
    // A skipped (zero-direction) ray counts as accepted without ever raising valid.
    assign accept    = (ray.ray_valid && ray.ray_ready) || skip_r;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            w_r           <= '0;
            h_r           <= '0;
            stride_r      <= '0;
            core_r        <= '0;
            dir_x_r       <= '0;
            dir_y_r       <= '0;
            dir_z_r       <= '0;
            right_x_r     <= '0;
            right_y_r     <= '0;
            right_z_r     <= '0;
            up_x_r        <= '0;
            up_y_r        <= '0;
            up_z_r        <= '0;
            total_r       <= '0;
            idx_r         <= '0;
            px_r          <= '0;
            py_r          <= '0;
            u_r           <= '0;
            v_r           <= '0;
            skip_r        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ray.ray_valid <= 1'b0;
            ray.ray_dir_x <= '0;
            ray.ray_dir_y <= '0;
            ray.ray_dir_z <= '0;
            ray.ray_px    <= '0;
            ray.ray_py    <= '0;
            ray.ray_index <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        w_r       <= image_width;
                        h_r       <= image_height;
                        stride_r  <= DIM_W'(stride_in);
                        core_r    <= core_id;
                        dir_x_r   <= cam_dir_x;
                        dir_y_r   <= cam_dir_y;
                        dir_z_r   <= cam_dir_z;
                        right_x_r <= cam_right_x;
                        right_y_r <= cam_right_y;
                        right_z_r <= cam_right_z;
                        up_x_r    <= cam_up_x;
                        up_y_r    <= cam_up_y;
                        up_z_r    <= cam_up_z;
                        busy      <= 1'b1;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    // core_id < W is assumed, so core_id mod W is core_id itself.
                    px_r    <= DIM_W'(core_r);
                    py_r    <= '0;
                    idx_r   <= IDX_W'(core_r);
                    total_r <= total_c;
                    // Also covers W==0 or H==0 (total 0): no beats, straight to done.
                    if (IDX_W'(core_r) >= total_c) begin
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        state <= S_COORD;
                    end
                end
                S_COORD: begin
                    u_r   <= $signed({1'b0, px_r}) - $signed({2'b00, w_r[DIM_W-1:1]});
                    v_r   <= $signed({2'b00, h_r[DIM_W-1:1]}) - $signed({1'b0, py_r});
                    state <= S_MAC;
                end
                S_MAC: begin
                    ray.ray_dir_x <= mac_x;
                    ray.ray_dir_y <= mac_y;
                    ray.ray_dir_z <= mac_z;
                    ray.ray_px    <= px_r;
                    ray.ray_py    <= py_r;
                    ray.ray_index <= idx_r;
                    if ((SKIP_ZERO != 0) && mac_zero) begin
                        skip_r        <= 1'b1;
                        ray.ray_valid <= 1'b0;
                    end else begin
                        skip_r        <= 1'b0;
                        ray.ray_valid <= 1'b1;
                    end
                    state <= S_EMIT;
                end
                S_EMIT: begin
                    if (accept) begin
                        ray.ray_valid <= 1'b0;
                        skip_r        <= 1'b0;
                        px_r          <= px_next;
                        py_r          <= py_next;
                        idx_r         <= idx_next;
                        if (frame_end) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            state <= S_COORD;
                        end
                    end
                end
                S_FINISH: begin
                    done          <= 1'b0;
                    busy          <= 1'b0;
                    ray.ray_valid <= 1'b0;
                    state         <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ray_gen_stream.sv
module tb_ray_gen_stream;
    localparam int COORD_W = 12;
    localparam int DIM_W   = 13;
    localparam int IDX_W   = 26;
    localparam int CORE_W  = 3;

    logic                      clk;
    logic                      reset_n;
    logic                      start;
    logic        [CORE_W-1:0]  core_id;
    logic        [CORE_W-1:0]  num_cores_m1;
    logic        [DIM_W-1:0]   image_width;
    logic        [DIM_W-1:0]   image_height;
    logic signed [COORD_W-1:0] cam_dir_x, cam_dir_y, cam_dir_z;
    logic signed [COORD_W-1:0] cam_right_x, cam_right_y, cam_right_z;
    logic signed [COORD_W-1:0] cam_up_x, cam_up_y, cam_up_z;
    logic                      busy;
    logic                      done;

    ray_gen_stream_if #(.COORD_W(COORD_W), .DIM_W(DIM_W), .IDX_W(IDX_W)) rif ();

    ray_gen_stream #(
        .COORD_W(COORD_W), .DIM_W(DIM_W), .IDX_W(IDX_W), .CORE_W(CORE_W), .SKIP_ZERO(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .core_id(core_id), .num_cores_m1(num_cores_m1),
        .image_width(image_width), .image_height(image_height),
        .cam_dir_x(cam_dir_x), .cam_dir_y(cam_dir_y), .cam_dir_z(cam_dir_z),
        .cam_right_x(cam_right_x), .cam_right_y(cam_right_y), .cam_right_z(cam_right_z),
        .cam_up_x(cam_up_x), .cam_up_y(cam_up_y), .cam_up_z(cam_up_z),
        .ray(rif), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          px;
        int          py;
        int          idx;
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] z;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    int    beats    = 0;
    int    done_cnt = 0;
    int    last_acc = 0;
    int    done_cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: enumerate this core's pixels and queue the expected beats.
    task automatic push_frame(input int core, input int stride, input int w, input int h,
                              input int dx, input int dy, input int dz,
                              input int rx, input int ry, input int rz,
                              input int ux, input int uy, input int uz);
        beat_t b;
        int    u, v, x, y, z;
        for (int i = core; i < w * h; i += stride) begin
            b.px  = i % w;
            b.py  = i / w;
            b.idx = i;
            u = b.px - w / 2;
            v = h / 2 - b.py;
            x = dx + rx * u + ux * v;
            y = dy + ry * u + uy * v;
            z = dz + rz * u + uz * v;
            b.x = x[11:0];
            b.y = y[11:0];
            b.z = z[11:0];
            if (!(b.x == 12'h0 && b.y == 12'h0 && b.z == 12'h0)) exp_q.push_back(b);
        end
    endtask

    // Scoreboard: pop and compare on every accepted beat.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n && rif.ray_valid && rif.ray_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_beat", 32'd1, 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    check_val("px",    32'(rif.ray_px),    b.px);
                    check_val("py",    32'(rif.ray_py),    b.py);
                    check_val("index", 32'(rif.ray_index), b.idx);
                    check_val("dir_x", {20'h0, rif.ray_dir_x}, {20'h0, b.x});
                    check_val("dir_y", {20'h0, rif.ray_dir_y}, {20'h0, b.y});
                    check_val("dir_z", {20'h0, rif.ray_dir_z}, {20'h0, b.z});
                end
                beats++;
                last_acc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic set_inputs(input int core, input int stride, input int w, input int h,
                              input int dx, input int dy, input int dz,
                              input int rx, input int ry, input int rz,
                              input int ux, input int uy, input int uz);
        int sm1;
        sm1          = stride - 1;
        core_id      = core[CORE_W-1:0];
        num_cores_m1 = sm1[CORE_W-1:0];
        image_width  = w[DIM_W-1:0];
        image_height = h[DIM_W-1:0];
        cam_dir_x = dx[11:0]; cam_dir_y = dy[11:0]; cam_dir_z = dz[11:0];
        cam_right_x = rx[11:0]; cam_right_y = ry[11:0]; cam_right_z = rz[11:0];
        cam_up_x = ux[11:0]; cam_up_y = uy[11:0]; cam_up_z = uz[11:0];
        push_frame(core, stride, w, h, dx, dy, dz, rx, ry, rz, ux, uy, uz);
    endtask

    task automatic run_frame(input int core, input int stride, input int w, input int h,
                             input int dx, input int dy, input int dz,
                             input int rx, input int ry, input int rz,
                             input int ux, input int uy, input int uz,
                             input bit chk_lat, input bit chk_done_lat, input bit stall);
        int          n_exp, b0, d0, lat, tmo;
        logic [11:0] sx;
        logic [25:0] sidx;
        @(posedge clk); #1;
        set_inputs(core, stride, w, h, dx, dy, dz, rx, ry, rz, ux, uy, uz);
        n_exp = exp_q.size();
        b0    = beats;
        d0    = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("busy_start", 32'(busy), 32'd1);
        if (chk_lat) begin
            lat = 1;
            while (!rif.ray_valid && lat < 50) begin
                @(posedge clk); #1;
                lat++;
            end
            check_val("start_lat", lat, 4);
            if (stall) begin
                rif.ray_ready = 1'b0;
                sx   = rif.ray_dir_x;
                sidx = rif.ray_index;
                // Camera changes and a second start mid-frame must both be ignored.
                cam_dir_x   = 12'h123;
                cam_right_x = 12'h055;
                start       = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    @(posedge clk); #1;
                    start = 1'b0;
                    check_val("stall_valid", 32'(rif.ray_valid), 32'd1);
                    check_val("stall_index", 32'(rif.ray_index), 32'(sidx));
                    check_val("stall_dir_x", {20'h0, rif.ray_dir_x}, {20'h0, sx});
                end
                check_val("stall_busy", 32'(busy), 32'd1);
                rif.ray_ready = 1'b1;
            end
        end
        tmo = 0;
        while (done_cnt == d0 && tmo < 5000) begin
            @(posedge clk); #1;
            tmo++;
        end
        check_val("done_seen", 32'(done_cnt - d0), 32'd1);
        check_val("beat_count", 32'(beats - b0), 32'(n_exp));
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        if (chk_done_lat) check_val("done_lat", 32'(done_cyc - last_acc), 32'd1);
        check_val("done_pulse", 32'(done), 32'd0);
        check_val("busy_end", 32'(busy), 32'd0);
        repeat (6) @(posedge clk);
        check_val("no_restart", 32'(beats - b0), 32'(n_exp));
    endtask

    initial begin
        int b0, d0, tmo;
        reset_n = 1'b0;
        start = 1'b0;
        rif.ray_ready = 1'b0;
        set_inputs(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", 32'(rif.ray_valid), 32'd0);
        check_val("rst_busy",  32'(busy), 32'd0);
        check_val("rst_done",  32'(done), 32'd0);
        check_val("rst_index", 32'(rif.ray_index), 32'd0);
        check_val("rst_dir_z", {20'h0, rif.ray_dir_z}, 32'd0);
        reset_n = 1'b1;
        rif.ray_ready = 1'b1;

        // Basic 4x2 frame, single core.
        run_frame(0, 1, 4, 2, 0, 0, 5, 1, 0, 0, 0, 1, 0, 1'b1, 1'b1, 1'b0);
        // Core 1 of 3: indices 1, 4, 7.
        run_frame(1, 3, 4, 2, 0, 0, 5, 1, 0, 0, 0, 1, 0, 1'b0, 1'b1, 1'b0);
        // Backpressure on the first beat.
        run_frame(0, 1, 4, 2, 0, 0, 5, 1, 0, 0, 0, 1, 0, 1'b1, 1'b1, 1'b1);
        // Zero-direction ray at px 2 is dropped.
        run_frame(0, 1, 4, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        // Large right vector: products wrap to 12 bits.
        run_frame(0, 1, 8, 1, 0, 0, 0, 2047, 0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        // Multi-row frame with 2 cores, odd dimensions.
        run_frame(1, 2, 5, 3, 3, -2, 7, 1, 1, 0, 2, 0, -1, 1'b0, 1'b0, 1'b0);
        // Empty image: no beats, done still pulses.
        run_frame(0, 1, 0, 2, 0, 0, 5, 1, 0, 0, 0, 1, 0, 1'b0, 1'b0, 1'b0);

        // Reset during the third beat of a frame.
        @(posedge clk); #1;
        set_inputs(0, 1, 4, 2, 0, 0, 5, 1, 0, 0, 0, 1, 0);
        b0 = beats;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tmo = 0;
        while (beats - b0 < 2 && tmo < 200) begin
            @(posedge clk); #1;
            tmo++;
        end
        check_val("rst_pre_beats", 32'(beats - b0), 32'd2);
        tmo = 0;
        while (!rif.ray_valid && tmo < 50) begin
            @(posedge clk); #1;
            tmo++;
        end
        check_val("third_beat_valid", 32'(rif.ray_valid), 32'd1);
        rif.ray_ready = 1'b0;
        reset_n = 1'b0;
        d0 = done_cnt;
        @(posedge clk); #1;
        check_val("abort_valid", 32'(rif.ray_valid), 32'd0);
        check_val("abort_busy",  32'(busy), 32'd0);
        check_val("abort_done",  32'(done), 32'd0);
        check_val("abort_index", 32'(rif.ray_index), 32'd0);
        check_val("abort_px",    32'(rif.ray_px), 32'd0);
        check_val("abort_dir_z", {20'h0, rif.ray_dir_z}, 32'd0);
        exp_q.delete();
        reset_n = 1'b1;
        rif.ray_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_val("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_frame(1, 2, 4, 2, 0, 0, 5, 1, 0, 0, 0, 1, 0, 1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
